// File: rtl/operand_stream_feeder.sv
// operand_stream_feeder
// Buffers one A/B operand pair (A by column, B by row) from the load path.
// Streams the pair to the systolic engine from k = K-1 down to k = 0.
// A completed load can be restreamed by a replay request without reloading.
module operand_stream_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int N            = 4,
    parameter int MAX_K        = 64,
    parameter int COUNTER_BITS = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [COUNTER_BITS-1:0]   cfg_len,
    input  logic                      cfg_replay,
    output logic                      cfg_error,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [N*DATA_WIDTH-1:0]   ld_a_col,
    input  logic [N*DATA_WIDTH-1:0]   ld_b_row,
    output logic                      a_input_valid,
    output logic                      b_input_valid,
    input  logic                      input_ready,
    output logic [COUNTER_BITS-1:0]   len_input,
    output logic [N*DATA_WIDTH-1:0]   a_data,
    output logic [N*DATA_WIDTH-1:0]   b_data,
    output logic                      busy,
    output logic                      done
);

    localparam int IDXW = (MAX_K > 1) ? $clog2(MAX_K) : 1;
    localparam int BW   = N * DATA_WIDTH;

    localparam logic [COUNTER_BITS-1:0] LEN_ONE = COUNTER_BITS'(1);
    localparam logic [COUNTER_BITS-1:0] LEN_MAX = COUNTER_BITS'(MAX_K);
    localparam logic [IDXW-1:0]         IDX_ONE = IDXW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [COUNTER_BITS-1:0] r_k_len;
    logic [COUNTER_BITS-1:0] r_loaded_len;
    logic [IDXW-1:0]         r_idx;
    logic                    r_loaded;
    logic                    r_done;
    logic                    r_cfg_error;

    // Operand buffers: written during LOAD, read combinationally during STREAM
    logic [BW-1:0] r_buf_a [MAX_K];
    logic [BW-1:0] r_buf_b [MAX_K];

    logic                    w_cfg_fire;
    logic                    w_len_bad;
    logic                    w_replay_bad;
    logic                    w_cfg_err;
    logic                    w_cfg_load;
    logic                    w_cfg_replay;
    logic [COUNTER_BITS-1:0] w_klen_m1;
    logic                    w_ld_fire;
    logic                    w_ld_last;
    logic                    w_st_fire;
    logic                    w_st_last;

    // Length legality is judged at full cfg_len width so large values cannot alias into range
    assign w_cfg_fire   = cfg_valid && (r_state == S_IDLE);
    assign w_len_bad    = (cfg_len == '0) || (cfg_len > LEN_MAX);
    assign w_replay_bad = cfg_replay && (!r_loaded || (cfg_len > r_loaded_len));
    assign w_cfg_err    = w_cfg_fire && (w_len_bad || w_replay_bad);
    assign w_cfg_load   = w_cfg_fire && !w_len_bad && !cfg_replay;
    assign w_cfg_replay = w_cfg_fire && !w_len_bad && !w_replay_bad && cfg_replay;

    assign w_klen_m1 = r_k_len - LEN_ONE;
    assign w_ld_fire = ld_valid && (r_state == S_LOAD);
    assign w_ld_last = w_ld_fire && (COUNTER_BITS'(r_idx) == w_klen_m1);
    assign w_st_fire = input_ready && (r_state == S_STREAM);
    assign w_st_last = w_st_fire && (r_idx == '0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cfg_load) begin
                    w_state_next = S_LOAD;
                end else if (w_cfg_replay) begin
                    w_state_next = S_STREAM;
                end
            end
            S_LOAD: begin
                if (w_ld_last) begin
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_st_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Job length, beat index, loaded bookkeeping and the done / error pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_k_len      <= '0;
            r_loaded_len <= '0;
            r_idx        <= '0;
            r_loaded     <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_error  <= 1'b0;
        end else begin
            r_done      <= w_st_last;
            r_cfg_error <= w_cfg_err;
            if (w_cfg_load) begin
                r_k_len  <= cfg_len;
                r_idx    <= '0;
                r_loaded <= 1'b0;
            end else if (w_cfg_replay) begin
                r_k_len <= cfg_len;
                r_idx   <= IDXW'(cfg_len - LEN_ONE);
            end
            if (w_ld_fire) begin
                // The last load beat leaves idx at K-1, ready to stream downward
                if (w_ld_last) begin
                    r_loaded     <= 1'b1;
                    r_loaded_len <= r_k_len;
                end else begin
                    r_idx <= r_idx + IDX_ONE;
                end
            end
            if (w_st_fire && !w_st_last) begin
                r_idx <= r_idx - IDX_ONE;
            end
        end
    end

    // Buffer write port; contents survive reset so they are not reset here
    always_ff @(posedge clk) begin
        if (w_ld_fire) begin
            r_buf_a[r_idx] <= ld_a_col;
            r_buf_b[r_idx] <= ld_b_row;
        end
    end

    // Outputs decoded from registered state only, never from input_ready
    always_comb begin
        cfg_ready     = (r_state == S_IDLE);
        ld_ready      = (r_state == S_LOAD);
        busy          = (r_state != S_IDLE);
        a_input_valid = (r_state == S_STREAM);
        b_input_valid = (r_state == S_STREAM);
        a_data        = '0;
        b_data        = '0;
        len_input     = '0;
        if (r_state == S_STREAM) begin
            a_data    = r_buf_a[r_idx];
            b_data    = r_buf_b[r_idx];
            len_input = r_k_len;
        end
        done      = r_done;
        cfg_error = r_cfg_error;
    end

endmodule

// File: tb/tb_operand_stream_feeder.sv
// Scoreboard bench for operand_stream_feeder: the stimulus side predicts beats
// into a queue, a negedge monitor pops and compares on each accepted beat.
module tb_operand_stream_feeder;

    localparam int DW  = 8;
    localparam int N   = 4;
    localparam int MAX_K = 64;
    localparam int CB  = 16;
    localparam int W   = N * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [CB-1:0] cfg_len = '0;
    logic          cfg_replay = 1'b0;
    logic          cfg_error;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [W-1:0]  ld_a_col = '0;
    logic [W-1:0]  ld_b_row = '0;
    logic          a_input_valid;
    logic          b_input_valid;
    logic          input_ready = 1'b0;
    logic [CB-1:0] len_input;
    logic [W-1:0]  a_data;
    logic [W-1:0]  b_data;
    logic          busy;
    logic          done;

    operand_stream_feeder #(.DATA_WIDTH(DW), .N(N), .MAX_K(MAX_K), .COUNTER_BITS(CB)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len),
        .cfg_replay(cfg_replay), .cfg_error(cfg_error),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_a_col(ld_a_col), .ld_b_row(ld_b_row),
        .a_input_valid(a_input_valid), .b_input_valid(b_input_valid), .input_ready(input_ready),
        .len_input(len_input), .a_data(a_data), .b_data(b_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [CB-1:0] len;
    } beat_t;

    beat_t        q[$];
    logic [W-1:0] m_a [MAX_K];
    logic [W-1:0] m_b [MAX_K];
    bit           m_loaded = 1'b0;
    int           m_loaded_len = 0;

    int checks = 0;
    int errors = 0;
    int err_seen = 0, err_exp = 0;
    int done_seen = 0, done_exp = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] dir_a(input int k);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'((i + 1) * (k + 1));
        return v;
    endfunction

    function automatic logic [W-1:0] dir_b(input int k);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(k);
        return v;
    endfunction

    function automatic logic pat(input int mode, input int c);
        logic [4:0] p;
        p = 5'b11001;
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c < 5) ? p[c] : 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    // Monitor: one line per accepted beat, plus protocol checks every cycle
    logic         prev_v = 1'b0, prev_r = 1'b0;
    logic [W-1:0] prev_a = '0, prev_b = '0;
    always @(negedge clk) begin
        beat_t e;
        if (!reset) begin
            prev_v = 1'b0;
        end else begin
            if (cfg_error) err_seen++;
            if (done) begin
                done_seen++;
                chk(!a_input_valid, "valid_with_done", a_input_valid, 0);
            end
            chk(a_input_valid == b_input_valid, "valid_pair", b_input_valid, a_input_valid);
            if (prev_v && !prev_r) begin
                chk(a_input_valid, "hold_valid", a_input_valid, 1);
                chk(a_data == prev_a && b_data == prev_b, "hold_data", a_data, prev_a);
            end
            if (a_input_valid && input_ready) begin
                if (q.size() == 0) begin
                    chk(0, "unexpected_beat", a_data, 0);
                end else begin
                    e = q.pop_front();
                    $display("beat a=%08h b=%08h len=%0d (exp a=%08h b=%08h len=%0d)",
                             a_data, b_data, len_input, e.a, e.b, e.len);
                    chk(a_data == e.a, "beat_a", a_data, e.a);
                    chk(b_data == e.b, "beat_b", b_data, e.b);
                    chk(len_input == e.len, "beat_len", len_input, e.len);
                end
            end else if (!a_input_valid) begin
                chk(a_data == '0 && b_data == '0 && len_input == '0, "idle_outputs",
                    a_data | b_data | W'(len_input), 0);
            end
            prev_v = a_input_valid;
            prev_r = input_ready;
            prev_a = a_data;
            prev_b = b_data;
        end
    end

    task automatic push_beats(input int len);
        for (int k = len - 1; k >= 0; k--) q.push_back('{m_a[k], m_b[k], CB'(len)});
    endtask

    // Issue one cfg request; act = 0 error, 1 load, 2 replay stream
    task automatic do_cfg(input int len, input bit rep, output int act);
        int g;
        g = 0;
        while (!cfg_ready && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        chk(cfg_ready, "cfg_ready_wait", cfg_ready, 1);
        if (len == 0 || len > MAX_K || (rep && (!m_loaded || len > m_loaded_len))) act = 0;
        else if (rep) act = 2;
        else act = 1;
        if (act == 0) err_exp++;
        if (act == 1) m_loaded = 1'b0;
        if (act == 2) push_beats(len);
        cfg_valid  = 1'b1;
        cfg_len    = CB'(len);
        cfg_replay = rep;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(posedge clk); #1;
        $display("cfg len=%0d replay=%0d -> act=%0d errors_seen=%0d", len, rep, act, err_seen);
        chk(err_seen == err_exp, "cfg_error_count", err_seen, err_exp);
        if (act == 0) begin
            chk(!ld_ready, "no_ld_ready_after_err", ld_ready, 0);
            chk(!busy, "idle_after_err", busy, 0);
        end else begin
            chk(busy, "busy_after_cfg", busy, 1);
        end
    endtask

    task automatic do_load(input int len, input bit directed);
        int cnt, guard;
        cnt = 0;
        guard = 0;
        while (cnt < len && guard < 1000) begin
            if (directed) begin
                ld_valid = 1'b1;
                ld_a_col = dir_a(cnt);
                ld_b_row = dir_b(cnt);
            end else begin
                ld_valid = ($urandom_range(0, 3) != 0);
                ld_a_col = W'($urandom);
                ld_b_row = W'($urandom);
            end
            @(negedge clk);
            if (ld_valid && ld_ready) begin
                m_a[cnt] = ld_a_col;
                m_b[cnt] = ld_b_row;
                cnt++;
            end
            @(posedge clk); #1;
            guard++;
        end
        ld_valid = 1'b0;
        chk(cnt == len, "load_beats", cnt, len);
        m_loaded = 1'b1;
        m_loaded_len = len;
        push_beats(len);
    endtask

    task automatic run_stream(input int mode);
        int c, start, n;
        c = 0;
        start = done_seen;
        n = q.size();
        done_exp++;
        input_ready = pat(mode, 0);
        while (done_seen == start && c < 300) begin
            @(posedge clk); #1;
            c++;
            input_ready = pat(mode, c);
        end
        input_ready = 1'b0;
        chk(done_seen == done_exp, "done_count", done_seen, done_exp);
        chk(q.size() == 0, "beats_left", q.size(), 0);
        if (mode == 0) chk(c == n + 1, "stream_cycles", c, n + 1);
    endtask

    int act;
    int ld_cnt;
    logic [W-1:0] first_a, first_b;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        chk(cfg_ready == 1'b1, "rst_cfg_ready", cfg_ready, 1);
        chk({busy, ld_ready, a_input_valid, b_input_valid, done, cfg_error} == 6'b0,
            "rst_flags", {busy, ld_ready, a_input_valid, b_input_valid, done, cfg_error}, 0);
        chk(len_input == '0 && a_data == '0, "rst_data", a_data, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // K=3 directed, always ready
        do_cfg(3, 0, act);
        do_load(3, 1);
        run_stream(0);

        // K=3 directed, ready pattern 1,0,0,1,1
        do_cfg(3, 0, act);
        do_load(3, 1);
        run_stream(1);

        // Illegal lengths, including values that would alias after truncation
        do_cfg(0, 0, act);
        do_cfg(MAX_K + 1, 0, act);
        do_cfg(MAX_K * 2, 0, act);
        do_cfg(16'hFFFF, 1, act);

        // Replay of the last K=3 load, then an over-long replay
        do_cfg(3, 1, act);
        run_stream(0);
        do_cfg(4, 1, act);

        // Reset during STREAM at idx 1
        do_cfg(3, 0, act);
        do_load(3, 1);
        input_ready = 1'b1;
        @(posedge clk); #1;
        input_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk(!a_input_valid && !b_input_valid, "rst_mid_valids", a_input_valid, 0);
        chk(!busy && cfg_ready, "rst_mid_idle", busy, 0);
        q.delete();
        m_loaded = 1'b0;
        m_loaded_len = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        do_cfg(3, 1, act);

        // K=1 with ld_valid held for three cycles
        do_cfg(1, 0, act);
        ld_valid = 1'b1;
        first_a  = W'($urandom);
        first_b  = W'($urandom);
        ld_a_col = first_a;
        ld_b_row = first_b;
        ld_cnt   = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ld_ready) ld_cnt++;
            @(posedge clk); #1;
            ld_a_col = W'($urandom);
            ld_b_row = W'($urandom);
        end
        ld_valid = 1'b0;
        chk(ld_cnt == 1, "k1_single_write", ld_cnt, 1);
        m_a[0] = first_a;
        m_b[0] = first_b;
        m_loaded = 1'b1;
        m_loaded_len = 1;
        push_beats(1);
        run_stream(0);

        // Randomized jobs: loads, replays and illegal requests
        for (int j = 0; j < 12; j++) begin
            int sel, len;
            bit rep;
            sel = $urandom_range(0, 9);
            if (j == 6) begin
                len = MAX_K;
                rep = 1'b0;
            end else if (sel < 5) begin
                len = $urandom_range(1, 10);
                rep = 1'b0;
            end else if (sel < 8) begin
                len = $urandom_range(1, m_loaded_len + 1);
                rep = 1'b1;
            end else begin
                len = ($urandom_range(0, 1) != 0) ? 0 : MAX_K + $urandom_range(1, 100);
                rep = 1'($urandom_range(0, 1));
            end
            do_cfg(len, rep, act);
            if (act == 1) do_load(len, 0);
            if (act != 0) run_stream(2);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
